// File: rtl/sw_gpio_in_pkg.sv
// Shared constants for the SW3 switch-input peripheral: widths, debounce default and register map.
package sw_gpio_in_pkg;

  localparam int SW_WIDTH    = 8;
  localparam int SW_DEBOUNCE = 16;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 32;

  typedef enum logic [ADDR_W-1:0] {
    SW_ADDR_STATE = 4'h0,
    SW_ADDR_EDGE  = 4'h4,
    SW_ADDR_MASK  = 4'h8
  } sw_addr_e;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

  function automatic logic [DATA_W-1:0] sw_zext(input sw_vec_t v);
    return {{(DATA_W-SW_WIDTH){1'b0}}, v};
  endfunction

endpackage

// File: rtl/sw_gpio_in_if.sv
// Single-cycle peripheral register port: request in cycle N, response in cycle N+1, never stalls.
interface sw_gpio_in_if;
  import sw_gpio_in_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output resp_valid, resp_rdata
  );

endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser, debounce counter and filtered state.
// o_toggle is high in the cycle whose closing edge flips o_state.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_pin,
  output logic o_state,
  output logic o_toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = (r_s2 != r_state);
  // The counter holds the number of earlier consecutive disagreeing cycles, so the flip lands on the Nth.
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_state <= r_s2;
      end
    end
  end

  assign o_state  = r_state;
  assign o_toggle = w_done;

endmodule

// File: rtl/sw_gpio_in.sv
// SW3 switch-input peripheral: debounced 8-bit switch state readable over a one-cycle register port.
// Define SW_IRQ_EN to add the EDGE (W1C) and MASK registers and the level interrupt irq_o.
module sw_gpio_in
  import sw_gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SW_WIDTH:1] sw_i,
  sw_gpio_in_if.slave       bus,
  output logic              irq_o
);

  sw_vec_t           w_state;
  sw_vec_t           w_toggle;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rd;
  logic              w_wr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk     (clk),
      .rstn    (rstn),
      .i_pin   (sw_i[i+1]),
      .o_state (w_state[i]),
      .o_toggle(w_toggle[i])
    );
  end

  assign w_rd = bus.req_valid && !bus.req_we;
  assign w_wr = bus.req_valid && bus.req_we;

`ifdef SW_IRQ_EN
  sw_vec_t r_edge_pend;
  sw_vec_t r_irq_mask;
  sw_vec_t w_edge_clr;
  logic    r_irq;
  logic    w_unused;

  assign w_edge_clr = (w_wr && bus.req_addr == SW_ADDR_EDGE) ? bus.req_wdata[SW_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_edge_pend <= '0;
      r_irq_mask  <= '0;
      r_irq       <= 1'b0;
    end else begin
      // A new edge in the same cycle as its W1C keeps the bit pending.
      r_edge_pend <= (r_edge_pend & ~w_edge_clr) | w_toggle;
      if (w_wr && bus.req_addr == SW_ADDR_MASK) begin
        r_irq_mask <= bus.req_wdata[SW_WIDTH-1:0];
      end
      r_irq <= |(r_edge_pend & r_irq_mask);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.req_addr)
      SW_ADDR_STATE: w_rdata = sw_zext(w_state);
      SW_ADDR_EDGE:  w_rdata = sw_zext(r_edge_pend);
      SW_ADDR_MASK:  w_rdata = sw_zext(r_irq_mask);
      default:       w_rdata = '0;
    endcase
  end

  assign irq_o    = r_irq;
  assign w_unused = &{1'b0, bus.req_wdata[DATA_W-1:SW_WIDTH]};
`else
  logic w_unused;

  always_comb begin
    w_rdata = '0;
    if (bus.req_addr == SW_ADDR_STATE) begin
      w_rdata = sw_zext(w_state);
    end
  end

  assign irq_o    = 1'b0;
  assign w_unused = &{1'b0, bus.req_wdata, w_toggle, w_wr};
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= bus.req_valid;
      r_resp_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_sw_gpio_in.sv
// Bench for sw_gpio_in: directed register scenarios and a vector table, then random traffic against a window-based model.
module tb_sw_gpio_in;
  import sw_gpio_in_pkg::*;

  localparam int D = 16;
`ifdef SW_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [SW_WIDTH:1] sw;
  logic              irq;

  sw_gpio_in_if bus_if();

  sw_gpio_in #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .sw_i (sw),
    .bus  (bus_if),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a bit flips once its synchronised pin disagreed with the state for the last D samples.
  sw_vec_t     m_s1, m_s2, m_st, m_pend, m_mask;
  logic        m_irq, m_rv;
  logic [31:0] m_rd;
  sw_vec_t     s2hist[$];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } tv_t;
  tv_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {24'h0, m_st};
      4'h4:    return IRQ_EN ? {24'h0, m_pend} : 32'h0;
      4'h8:    return IRQ_EN ? {24'h0, m_mask} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    sw_vec_t tog;
    sw_vec_t clr;
    bit      all;
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0; m_mask = '0;
      m_irq = 1'b0; m_rv = 1'b0; m_rd = 32'h0;
      s2hist.delete();
    end else begin
      m_rv  = bus_if.req_valid;
      m_rd  = (bus_if.req_valid && !bus_if.req_we) ? model_read(bus_if.req_addr) : 32'h0;
      m_irq = IRQ_EN && (|(m_pend & m_mask));
      s2hist.push_back(m_s2);
      if (s2hist.size() > D) void'(s2hist.pop_front());
      tog = '0;
      if (s2hist.size() == D) begin
        for (int b = 0; b < SW_WIDTH; b++) begin
          all = 1'b1;
          foreach (s2hist[j]) if (s2hist[j][b] == m_st[b]) all = 1'b0;
          tog[b] = all;
        end
      end
      clr = (bus_if.req_valid && bus_if.req_we && bus_if.req_addr == 4'h4) ? bus_if.req_wdata[7:0] : '0;
      if (IRQ_EN) begin
        m_pend = (m_pend & ~clr) | tog;
        if (bus_if.req_valid && bus_if.req_we && bus_if.req_addr == 4'h8) m_mask = bus_if.req_wdata[7:0];
      end
      m_st = m_st ^ tog;
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_resp_valid", 32'(bus_if.resp_valid), 32'(m_rv));
    chk("model_resp_rdata", bus_if.resp_rdata, m_rd);
    chk("model_irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wd;
    tick();
    bus_if.req_valid = 1'b0;
    rd = bus_if.resp_rdata;
    chk("bus_resp_valid", 32'(bus_if.resp_valid), 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_op(1'b0, addr, 32'h0, rd);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    bus_op(1'b1, addr, wd, rd);
    chk("wr_rdata_zero", rd, 32'h0);
  endtask

  initial begin
    int b;
    rstn = 1'b0;
    sw   = '1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 4'h0;
    bus_if.req_wdata = 32'h0;

    // Reset with switches high, then back-to-back STATE reads across the debounce window
    tick();
    tick();
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'h0);
    chk("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rstn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = 1'b0;
      bus_if.req_addr  = 4'h0;
      tick();
      chk("t1_b2b_valid", 32'(bus_if.resp_valid), 32'h1);
      chk($sformatf("t1_state_edge%0d", k), bus_if.resp_rdata, (k >= 19) ? 32'hFF : 32'h0);
    end
    bus_if.req_valid = 1'b0;
    rd_chk("t1_edge_after_reset", 4'h4, IRQ_EN ? 32'hFF : 32'h0);
    wr(4'h4, 32'hFF);
    sw = '0;
    idle(D + 4);
    wr(4'h4, 32'hFF);
    rd_chk("t1_state_fall", 4'h0, 32'h0);
    rd_chk("t1_edge_cleared", 4'h4, 32'h0);

    // Short glitch on sw_i[1]
    sw = 8'h01;
    idle(5);
    sw = 8'h00;
    idle(30);
    rd_chk("t2_glitch_state", 4'h0, 32'h0);
    rd_chk("t2_glitch_edge", 4'h4, 32'h0);

    // Clean press, mask, interrupt and W1C
    sw = 8'h05;
    idle(40);
    rd_chk("t3_state", 4'h0, 32'h05);
    rd_chk("t3_edge", 4'h4, IRQ_EN ? 32'h05 : 32'h0);
    wr(4'h8, 32'h01);
    idle(2);
    chk("t3_irq_set", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    wr(4'h4, 32'h01);
    chk("t3_irq_hold", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    tick();
    chk("t3_irq_clr", 32'(irq), 32'h0);
    rd_chk("t3_edge_w1c", 4'h4, IRQ_EN ? 32'h04 : 32'h0);

    // W1C of bit1 landing on the very edge where bit1 flips
    sw = 8'h07;
    idle(D);
    rd_chk("t4_state_pre", 4'h0, 32'h05);
    wr(4'h4, 32'h02);
    rd_chk("t4_collision_edge", 4'h4, IRQ_EN ? 32'h06 : 32'h0);
    rd_chk("t4_state_post", 4'h0, 32'h07);

    // Back-to-back register vectors
    tbl[0]  = '{1'b0, 4'hC, 32'h0,  32'h0};
    tbl[1]  = '{1'b1, 4'h0, 32'hAA, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,  32'h07};
    tbl[3]  = '{1'b1, 4'h8, 32'h03, 32'h0};
    tbl[4]  = '{1'b0, 4'h8, 32'h0,  IRQ_EN ? 32'h03 : 32'h0};
    tbl[5]  = '{1'b0, 4'h4, 32'h0,  IRQ_EN ? 32'h06 : 32'h0};
    tbl[6]  = '{1'b1, 4'h4, 32'h06, 32'h0};
    tbl[7]  = '{1'b0, 4'h4, 32'h0,  32'h0};
    tbl[8]  = '{1'b1, 4'hC, 32'hFF, 32'h0};
    tbl[9]  = '{1'b0, 4'h2, 32'h0,  32'h0};
    tbl[10] = '{1'b0, 4'h8, 32'h0,  IRQ_EN ? 32'h03 : 32'h0};
    tbl[11] = '{1'b1, 4'h8, 32'h0,  32'h0};
    tbl[12] = '{1'b0, 4'h8, 32'h0,  32'h0};
    tbl[13] = '{1'b0, 4'h0, 32'h0,  32'h07};
    for (int i = 0; i < 14; i++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = tbl[i].we;
      bus_if.req_addr  = tbl[i].addr;
      bus_if.req_wdata = tbl[i].wd;
      tick();
      chk($sformatf("t5_vec%0d_valid", i), 32'(bus_if.resp_valid), 32'h1);
      chk($sformatf("t5_vec%0d_rdata", i), bus_if.resp_rdata, tbl[i].exp);
    end
    bus_if.req_valid = 1'b0;
    tick();
    chk("t5_idle_valid", 32'(bus_if.resp_valid), 32'h0);

    // Reset landing on an in-flight read
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 4'h0;
    rstn = 1'b0;
    tick();
    bus_if.req_valid = 1'b0;
    chk("rst_mid_valid", 32'(bus_if.resp_valid), 32'h0);
    chk("rst_mid_rdata", bus_if.resp_rdata, 32'h0);
    rstn = 1'b1;
    rd_chk("rst_mid_state", 4'h0, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        b = $urandom_range(1, SW_WIDTH);
        sw[b] = ~sw[b];
      end
      bus_if.req_valid = 1'($urandom_range(0, 1));
      bus_if.req_we    = 1'($urandom_range(0, 1));
      bus_if.req_addr  = ($urandom_range(0, 4) == 4) ? 4'($urandom) : 4'($urandom_range(0, 2) * 4);
      bus_if.req_wdata = $urandom;
      rstn = ($urandom_range(0, 999) != 0);
      tick();
    end
    rstn = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
